// File: rtl/ring_buffer_pkg.sv
// Shared helpers for the multi-channel ring buffer: explicit pointer wrap and round-robin search.
// Used by ring_buffer_ch and ring_buffer_vc (optional almost-full flag: RING_BUFFER_VC_AFULL_EN).
package ring_buffer_pkg;

  localparam int unsigned RR_MAX_CH = 32;
  localparam int unsigned RR_IDX_W  = $clog2(RR_MAX_CH);

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned size);
    return (ptr == size - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

  // First set bit after start, wrapping, with start itself checked last. Bits above the
  // real channel count must be zero, so wrapping modulo RR_MAX_CH keeps the same order.
  function automatic int unsigned rr_pick(input logic [RR_MAX_CH-1:0] mask,
                                          input int unsigned start);
    int unsigned pick;
    logic [RR_IDX_W-1:0] idx;
    pick = start;
    for (int unsigned i = RR_MAX_CH; i >= 1; i--) begin
      idx = RR_IDX_W'(start + i);
      if (mask[idx]) pick = 32'(idx);
    end
    return pick;
  endfunction

endpackage

// File: rtl/ring_buffer_ch.sv
// One circular queue of arbitrary depth with count, synchronous flush and push/pop ports.
// Part of ring_buffer_vc (almost-full flag built in the top, under RING_BUFFER_VC_AFULL_EN).
module ring_buffer_ch
  import ring_buffer_pkg::*;
#(
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned BUFFER_SIZE = 8,
  localparam int unsigned PTR_W      = $clog2(BUFFER_SIZE),
  localparam int unsigned CNT_W      = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [DATA_SIZE-1:0] data_i,
  output logic                 ready_o,
  output logic [DATA_SIZE-1:0] data_o,
  output logic [CNT_W-1:0]     count_o,
  output logic [CNT_W-1:0]     count_next_o
);

  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_SIZE-1:0] mem_q [BUFFER_SIZE];
  logic                 push_ok;
  logic                 pop_ok;

  // Acceptance uses the pre-edge count only, so a full queue refuses even while popping.
  assign ready_o = (count_q != CNT_W'(BUFFER_SIZE));
  assign push_ok = push_i && ready_o && !flush_i;
  assign pop_ok  = pop_i && (count_q != '0) && !flush_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = PTR_W'(ptr_inc(32'(tail_q), BUFFER_SIZE));
      if (pop_ok)  head_d = PTR_W'(ptr_inc(32'(head_q), BUFFER_SIZE));
      if (push_ok && !pop_ok) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[tail_q] <= data_i;
  end

  assign data_o       = mem_q[head_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/ring_buffer_vc.sv
// CHANNELS independent ring buffers merged onto one output by a round-robin grant register.
// Define RING_BUFFER_VC_AFULL_EN to build the registered per-channel almost-full flags.
module ring_buffer_vc
  import ring_buffer_pkg::*;
#(
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned BUFFER_SIZE = 8,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned AFULL_LEVEL = BUFFER_SIZE - 2,
  localparam int unsigned CNT_W      = $clog2(BUFFER_SIZE + 1),
  localparam int unsigned CH_W       = $clog2(CHANNELS)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [CHANNELS-1:0]           buf_rst_i,
  input  logic [CHANNELS-1:0]           rx_i,
  output logic [CHANNELS-1:0]           rx_ack_o,
  input  logic [CHANNELS*DATA_SIZE-1:0] data_i,
  output logic [CHANNELS*CNT_W-1:0]     count_o,
  output logic [CHANNELS-1:0]           afull_o,
  output logic                          tx_o,
  input  logic                          tx_ack_i,
  output logic [DATA_SIZE-1:0]          data_o,
  output logic [CH_W-1:0]               tx_ch_o
);

  if (CHANNELS < 2 || CHANNELS > RR_MAX_CH || BUFFER_SIZE < 2 ||
      AFULL_LEVEL < 1 || AFULL_LEVEL > BUFFER_SIZE) begin : g_param_check
    $error("ring_buffer_vc: illegal parameter combination");
  end

  logic [CNT_W-1:0]     cnt      [CHANNELS];
  logic [CNT_W-1:0]     cnt_next [CHANNELS];
  logic [DATA_SIZE-1:0] head     [CHANNELS];
  logic [CHANNELS-1:0]  pop;
  logic [CHANNELS-1:0]  nonempty_next;
  logic [CH_W-1:0]      grant_q, grant_d;
  logic                 pop_fire;

  assign tx_o     = (cnt[grant_q] != '0);
  assign pop_fire = tx_o && tx_ack_i;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign pop[gi]           = pop_fire && (grant_q == CH_W'(gi));
    assign nonempty_next[gi] = (cnt_next[gi] != '0);
    assign count_o[gi*CNT_W +: CNT_W] = cnt[gi];

    ring_buffer_ch #(
      .DATA_SIZE  (DATA_SIZE),
      .BUFFER_SIZE(BUFFER_SIZE)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (buf_rst_i[gi]),
      .push_i      (rx_i[gi]),
      .pop_i       (pop[gi]),
      .data_i      (data_i[gi*DATA_SIZE +: DATA_SIZE]),
      .ready_o     (rx_ack_o[gi]),
      .data_o      (head[gi]),
      .count_o     (cnt[gi]),
      .count_next_o(cnt_next[gi])
    );
  end

  // The grant only moves after a pop or when parked on an empty channel, so an
  // offered word stays put until taken (a flush of the granted channel excepted).
  always_comb begin
    grant_d = grant_q;
    if (pop_fire || !tx_o) begin
      grant_d = CH_W'(rr_pick(RR_MAX_CH'(nonempty_next), 32'(grant_q)));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) grant_q <= '0;
    else         grant_q <= grant_d;
  end

  assign data_o  = head[grant_q];
  assign tx_ch_o = grant_q;

`ifdef RING_BUFFER_VC_AFULL_EN
  logic [CHANNELS-1:0] afull_q, afull_d;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_afull
    assign afull_d[gi] = (cnt_next[gi] >= CNT_W'(AFULL_LEVEL));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) afull_q <= '0;
    else         afull_q <= afull_d;
  end

  assign afull_o = afull_q;
`else
  assign afull_o = '0;
`endif

endmodule

// File: tb/tb_ring_buffer_vc.sv
// Self-checking bench for ring_buffer_vc: vector table plus scoreboarded multi-cycle sequences.
// Honours RING_BUFFER_VC_AFULL_EN when deciding the expected almost-full flags.
module tb_ring_buffer_vc;

`ifdef RING_BUFFER_VC_AFULL_EN
  localparam bit AFULL_ON = 1'b1;
`else
  localparam bit AFULL_ON = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic         clk = 1'b0;
  logic         rst_n;
  // main instance: 4 channels x 8 entries
  logic [3:0]   buf_rst, rx, rx_ack, afull;
  logic [127:0] data_in;
  logic [15:0]  count;
  logic         tx, tx_ack;
  logic [31:0]  data_out;
  logic [1:0]   tx_ch;
  // wrap instance: 2 channels x 5 entries
  logic [1:0]   b5_buf_rst, b5_rx, b5_rx_ack, b5_afull;
  logic [63:0]  b5_data_in;
  logic [5:0]   b5_count;
  logic         b5_tx, b5_tx_ack;
  logic [31:0]  b5_data_out;
  logic [0:0]   b5_tx_ch;

  always #5 clk = ~clk;

  ring_buffer_vc #(.DATA_SIZE(32), .BUFFER_SIZE(8), .CHANNELS(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .buf_rst_i(buf_rst), .rx_i(rx), .rx_ack_o(rx_ack),
    .data_i(data_in), .count_o(count), .afull_o(afull), .tx_o(tx), .tx_ack_i(tx_ack),
    .data_o(data_out), .tx_ch_o(tx_ch)
  );

  ring_buffer_vc #(.DATA_SIZE(32), .BUFFER_SIZE(5), .CHANNELS(2)) dut5 (
    .clk_i(clk), .rst_ni(rst_n), .buf_rst_i(b5_buf_rst), .rx_i(b5_rx), .rx_ack_o(b5_rx_ack),
    .data_i(b5_data_in), .count_o(b5_count), .afull_o(b5_afull), .tx_o(b5_tx),
    .tx_ack_i(b5_tx_ack), .data_o(b5_data_out), .tx_ch_o(b5_tx_ch)
  );

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    logic [3:0]  rx;
    logic [31:0] data;
    logic [3:0]  exp_cnt1;
    logic        exp_ack1;
    logic        exp_afull1;
    logic        exp_tx;
    logic [1:0]  exp_ch;
    logic [31:0] exp_head;
  } vec_t;

  exp_t        sb_q[$];
  logic [31:0] sb5_q[$];
  exp_t        mon_e;
  logic [31:0] mon5_d;
  vec_t        vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("check %s: 0x%0h ok", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] cnt_of(input int c);
    return count[c*4 +: 4];
  endfunction

  function automatic logic afull_model(input int cnt);
    return AFULL_ON && (cnt >= 6);
  endfunction

  // Pops are compared against the scoreboard when the consumer takes a word.
  always @(negedge clk) begin
    if (rst_n && tx && tx_ack) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got ch %0d data 0x%0h, expected no transfer", tx_ch, data_out);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pop_data", {32'd0, data_out}, {32'd0, mon_e.d});
        chk("pop_ch", {62'd0, tx_ch}, {62'd0, mon_e.ch});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b5_tx && b5_tx_ack) begin
      if (sb5_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b5_unexpected_pop: got data 0x%0h, expected no transfer", b5_data_out);
      end else begin
        mon5_d = sb5_q.pop_front();
        chk("b5_pop_data", {32'd0, b5_data_out}, {32'd0, mon5_d});
        chk("b5_pop_ch", {63'd0, b5_tx_ch}, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 9; i++) begin
      vecs[i].rx         = 4'b0010;
      vecs[i].data       = 32'h10 + i;
      vecs[i].exp_cnt1   = (i < 8) ? 4'(i + 1) : 4'd8;
      vecs[i].exp_ack1   = (i < 7);
      vecs[i].exp_afull1 = afull_model((i < 8) ? i + 1 : 8);
      vecs[i].exp_tx     = 1'b1;
      vecs[i].exp_ch     = 2'd1;
      vecs[i].exp_head   = 32'h10;
    end

    rst_n = 1'b0; buf_rst = '0; rx = '0; data_in = '0; tx_ack = 1'b0;
    b5_buf_rst = '0; b5_rx = '0; b5_data_in = '0; b5_tx_ack = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    chk("reset_rx_ack", {60'd0, rx_ack}, 64'hF);
    chk("reset_count", {48'd0, count}, 64'd0);
    chk("reset_afull", {60'd0, afull}, 64'd0);
    chk("reset_tx", {63'd0, tx}, 64'd0);
    chk("reset_tx_ch", {62'd0, tx_ch}, 64'd0);
    chk("reset_b5_rx_ack", {62'd0, b5_rx_ack}, 64'h3);

    // fill ch1 to full without consuming; last vector is a refused push
    for (int i = 0; i < 9; i++) begin
      rx = vecs[i].rx;
      data_in[32 +: 32] = vecs[i].data;
      step();
      chk("fill_count1", {60'd0, cnt_of(1)}, {60'd0, vecs[i].exp_cnt1});
      chk("fill_rx_ack1", {63'd0, rx_ack[1]}, {63'd0, vecs[i].exp_ack1});
      chk("fill_afull1", {63'd0, afull[1]}, {63'd0, vecs[i].exp_afull1});
      chk("fill_tx", {63'd0, tx}, {63'd0, vecs[i].exp_tx});
      chk("fill_tx_ch", {62'd0, tx_ch}, {62'd0, vecs[i].exp_ch});
      chk("fill_head", {32'd0, data_out}, {32'd0, vecs[i].exp_head});
    end
    rx = '0;

    for (int k = 0; k < 8; k++) sb_q.push_back('{ch: 2'd1, d: 32'h10 + k});
    tx_ack = 1'b1;
    repeat (8) step();
    tx_ack = 1'b0;
    chk("drain1_sb_empty", 64'(sb_q.size()), 64'd0);
    chk("drain1_count1", {60'd0, cnt_of(1)}, 64'd0);
    chk("drain1_tx", {63'd0, tx}, 64'd0);

    // depth-5 queue: continuous push/pop through several pointer wraps
    for (int i = 0; i < 12; i++) begin
      b5_rx = 2'b01;
      b5_data_in[31:0] = 32'(i);
      b5_tx_ack = 1'b1;
      sb5_q.push_back(32'(i));
      step();
      chk("b5_count_le1", {63'd0, (b5_count[2:0] <= 3'd1)}, 64'd1);
    end
    b5_rx = '0;
    step();
    step();
    b5_tx_ack = 1'b0;
    chk("b5_sb_empty", 64'(sb5_q.size()), 64'd0);
    chk("b5_count0", {61'd0, b5_count[2:0]}, 64'd0);

    // interleave: ch0 {A0,A1}, ch2 {C0,C1}
    rx = 4'b0001; data_in[0 +: 32] = 32'hA0; step();
    data_in[0 +: 32] = 32'hA1; step();
    rx = 4'b0100; data_in[64 +: 32] = 32'hC0; step();
    data_in[64 +: 32] = 32'hC1; step();
    rx = '0;
    chk("rr_hold_ch", {62'd0, tx_ch}, 64'd0);
    chk("rr_hold_head", {32'd0, data_out}, 64'hA0);
    sb_q.push_back('{ch: 2'd0, d: 32'hA0});
    sb_q.push_back('{ch: 2'd2, d: 32'hC0});
    sb_q.push_back('{ch: 2'd0, d: 32'hA1});
    sb_q.push_back('{ch: 2'd2, d: 32'hC1});
    tx_ack = 1'b1;
    repeat (4) step();
    tx_ack = 1'b0;
    chk("rr_sb_empty", 64'(sb_q.size()), 64'd0);
    chk("rr_counts", {48'd0, count}, 64'd0);

    // ch3 full: push during pop must be refused
    rx = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      data_in[96 +: 32] = 32'h30 + i;
      step();
    end
    chk("full3_count", {60'd0, cnt_of(3)}, 64'd8);
    chk("full3_rx_ack", {63'd0, rx_ack[3]}, 64'd0);
    chk("full3_tx_ch", {62'd0, tx_ch}, 64'd3);
    chk("full3_head", {32'd0, data_out}, 64'h30);
    data_in[96 +: 32] = 32'h99;
    tx_ack = 1'b1;
    sb_q.push_back('{ch: 2'd3, d: 32'h30});
    step();
    rx = '0;
    tx_ack = 1'b0;
    chk("full3_pop_count", {60'd0, cnt_of(3)}, 64'd7);
    chk("full3_pop_head", {32'd0, data_out}, 64'h31);
    chk("full3_pop_rx_ack", {63'd0, rx_ack[3]}, 64'd1);
    for (int k = 1; k < 8; k++) sb_q.push_back('{ch: 2'd3, d: 32'h30 + k});
    tx_ack = 1'b1;
    repeat (7) step();
    tx_ack = 1'b0;
    chk("full3_sb_empty", 64'(sb_q.size()), 64'd0);
    chk("full3_count0", {60'd0, cnt_of(3)}, 64'd0);

    // flush of the granted channel with a concurrent push
    rx = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      data_in[64 +: 32] = 32'h50 + i;
      step();
    end
    chk("flush_pre_count2", {60'd0, cnt_of(2)}, 64'd3);
    chk("flush_pre_tx_ch", {62'd0, tx_ch}, 64'd2);
    buf_rst = 4'b0100;
    data_in[64 +: 32] = 32'hEE;
    step();
    buf_rst = '0;
    rx = '0;
    chk("flush_count2", {60'd0, cnt_of(2)}, 64'd0);
    chk("flush_tx", {63'd0, tx}, 64'd0);
    chk("flush_rx_ack", {60'd0, rx_ack}, 64'hF);
    step();
    chk("flush_discard_count2", {60'd0, cnt_of(2)}, 64'd0);
    rx = 4'b0100;
    data_in[64 +: 32] = 32'hAB;
    step();
    rx = '0;
    chk("lat1_tx", {63'd0, tx}, 64'd1);
    chk("lat1_tx_ch", {62'd0, tx_ch}, 64'd2);
    chk("lat1_head", {32'd0, data_out}, 64'hAB);
    sb_q.push_back('{ch: 2'd2, d: 32'hAB});
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    chk("lat1_sb_empty", 64'(sb_q.size()), 64'd0);

    // asynchronous reset in the middle of streaming traffic on ch1
    tx_ack = 1'b1;
    rx = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      data_in[32 +: 32] = 32'h60 + i;
      sb_q.push_back('{ch: 2'd1, d: 32'h60 + i});
      step();
    end
    chk("pre_rst_count1", {60'd0, cnt_of(1)}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", {48'd0, count}, 64'd0);
    chk("async_rst_tx", {63'd0, tx}, 64'd0);
    chk("async_rst_rx_ack", {60'd0, rx_ack}, 64'hF);
    chk("async_rst_sb_left", 64'(sb_q.size()), 64'd1);
    sb_q.delete();
    rx = '0;
    tx_ack = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_tx", {63'd0, tx}, 64'd0);
    chk("post_rst_count", {48'd0, count}, 64'd0);
    chk("end_sb5_empty", 64'(sb5_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_buffer_vc.md
# ring_buffer_vc

Multi-channel successor to the single-queue ring buffer. It holds CHANNELS independent circular queues of configurable, not necessarily power-of-2, depth, each with its own valid/ack input port, occupancy count and synchronous flush. A round-robin arbiter merges the queues onto one output port that reports the channel index. It sits between several producers (e.g. per-peripheral DMA streams) and a single shared consumer.

## Interface
- DATA_SIZE, 32, payload width in bits
- BUFFER_SIZE, 8, entries per channel; any value ≥ 2
- CHANNELS, 4, number of queues; ≥ 2
- AFULL_LEVEL, BUFFER_SIZE-2, almost-full threshold; 1..BUFFER_SIZE
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- buf_rst_i  in  CHANNELS  per-channel synchronous flush
- rx_i  in  CHANNELS  producer valid, per channel
- rx_ack_o  out  CHANNELS  per-channel not-full / ready
- data_i  in  CHANNELS×DATA_SIZE  producer payload, channel c in slice c
- count_o  out  CHANNELS×$clog2(BUFFER_SIZE+1)  occupancy per channel
- afull_o  out  CHANNELS  almost-full flag per channel
- tx_o  out  1  output valid
- tx_ack_i  in  1  consumer ready
- data_o  out  DATA_SIZE  head entry of the granted channel
- tx_ch_o  out  $clog2(CHANNELS)  granted channel index

## Operation
- Push on channel c: rx_i[c] && rx_ack_o[c] in the same cycle. rx_ack_o[c] = (count[c] != BUFFER_SIZE). It depends only on registered state.
- Pop: tx_o && tx_ack_i. Removes the head of channel g, where g is the grant register.
- Pointers wrap explicitly: a pointer at BUFFER_SIZE-1 goes to 0. No power-of-2 assumption.
- count[c] updates as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- A full channel cannot accept a push in the same cycle as its pop. Acceptance is based on the pre-edge count.
- An empty channel cannot be popped. A push into it is visible on the next cycle.
- tx_o = (count[g] != 0). data_o = head of g. tx_ch_o = g.
- Grant update at each edge, only when (tx_o && tx_ack_i) or count[g] == 0:
  - g moves to the first channel, in order g+1, g+2, …, g (wrapping, g last), whose post-edge count is nonzero.
  - If no such channel exists, g is unchanged.
- Grant hold: while tx_o && !tx_ack_i, g, data_o and tx_ch_o stay stable.
- Flush: buf_rst_i[c] zeroes the pointers and count of channel c at the next edge.
  - Flush overrides push and pop on c in that cycle.
  - If c == g, tx_o drops next cycle. This is the only permitted violation of the hold rule.
- Storage array is not reset. Pointers, counts and g are reset.

## Timing
- Reset values:
  - rx_ack_o = all 1
  - count_o = 0
  - afull_o = 0
  - tx_o = 0
  - tx_ch_o = 0
  - data_o is don't-care while tx_o = 0
- Push-to-tx_o latency is 1 cycle when the channel is already granted.
- When the grant must move to the pushed channel, latency is ≤ 2 cycles.
- Back-to-back pops from one channel are not possible while another channel is nonempty. The grant rotates after every pop. Each pop sustains 1 transfer/cycle.
- count_o and afull_o are registered and reflect the state after the previous edge.
- Reset assertion mid-operation empties all channels immediately and asynchronously.

## Configuration
- RING_BUFFER_VC_AFULL_EN
  - Defined: afull_o[c] = (count[c] ≥ AFULL_LEVEL), registered.
  - Undefined: afull_o is tied to 0, and no comparator logic is generated.
  - All other behaviour is identical in both cases.

## Structure
- Package ring_buffer_pkg holds:
  - function ptr_inc(ptr, size) for explicit wrap
  - function rr_pick(mask, start) for the round-robin search
- One sub-module, ring_buffer_ch, holds a single queue: storage, head/tail, count, flush, push/pop ports.
- ring_buffer_vc instantiates CHANNELS copies of ring_buffer_ch and adds the grant register and output mux.

## Test plan
- Reset, then push 8 words 0x10..0x17 on ch1 with tx_ack_i = 0.
  - Expect count_o[1] = 8 and rx_ack_o[1] = 0.
  - With the macro defined, afull_o[1] = 1 from count 6.
- BUFFER_SIZE = 5: push and pop 12 words 0x0..0xB on ch0 with tx_ack_i = 1.
  - Expect output in order across the wrap, and count never above 1.
- ch0 holds A0,A1 and ch2 holds C0,C1, with tx_ack_i = 1.
  - Expect output A0(0), C0(2), A1(0), C1(2).
- ch3 full, with simultaneous rx_i[3] = 1 and a pop of ch3.
  - Expect the push refused, count 7, and the head advanced.
- ch2 granted and holding 3 entries, tx_ack_i = 0; assert buf_rst_i[2] together with rx_i[2].
  - Next cycle: count_o[2] = 0, tx_o = 0, push discarded.
- Assert rst_ni = 0 mid-traffic.
  - Immediately: all counts 0, tx_o = 0, rx_ack_o all 1.
